// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-cycle advance/hold/bubble decisions for the four pipeline
// latches, a redirect held across D-cache misses, sticky halt and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_DRen,
    input  logic             exmem_DWen,
    input  logic             idex_DRen,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             redirect,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             redirect_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, HALT} state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic redirect_sel;
    } ctrl_t;

    localparam ctrl_t C_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
    localparam ctrl_t C_REDIR  = 9'b1_1_1_1_1_1_1_1_1;
    localparam ctrl_t C_LDUSE  = 9'b0_0_0_1_1_1_0_1_0;
    localparam ctrl_t C_IMISS  = 9'b0_1_1_1_0_1_0_1_0;
    localparam ctrl_t C_FLOW   = 9'b1_1_0_1_0_1_0_1_0;

    state_t state, next_state;
    logic   pend, next_pend;
    logic   halted_q, next_halted;
    ctrl_t  ctrl, ctrl_local;

    logic mem_miss, load_use;

    assign mem_miss = (exmem_DRen | exmem_DWen) & ~dhit;
    assign load_use = idex_DRen & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    // Decision when no redirect is in play: load-use beats an I-cache miss.
    always_comb begin
        ctrl_local = C_FLOW;
        if (load_use)
            ctrl_local = C_LDUSE;
        else if (!ihit)
            ctrl_local = C_IMISS;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= INIT;
            pend     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= next_state;
            pend     <= next_pend;
            halted_q <= next_halted;
        end
    end

    always_comb begin
        next_state  = state;
        next_pend   = pend;
        next_halted = halted_q;
        unique case (state)
            INIT: next_state = RUN;
            RUN: begin
                if (halt_wb) begin
                    next_state  = HALT;
                    next_halted = 1'b1;
                end else if (mem_miss) begin
                    next_state = MEM_WAIT;
                    next_pend  = redirect;
                end
            end
            MEM_WAIT: begin
                if (dhit) begin
                    next_state = RUN;
                    next_pend  = 1'b0;
                end
            end
            HALT: next_state = HALT;
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        ctrl = C_FREEZE;
        unique case (state)
            RUN: begin
                if (!halt_wb && !mem_miss)
                    ctrl = redirect ? C_REDIR : ctrl_local;
            end
            // A redirect captured on miss entry is replayed on the cycle the miss resolves.
            MEM_WAIT: begin
                if (dhit)
                    ctrl = (pend | redirect) ? C_REDIR : ctrl_local;
            end
            default: ctrl = C_FREEZE;
        endcase
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwb_en     = ctrl.memwb_en;
    assign redirect_sel = ctrl.redirect_sel;
    assign halted       = halted_q;

    logic stall_inc;
    assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !ctrl.pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ctrl.redirect_sel && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
